// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - fetch unit bus: redirect, stall, imem request/response, instruction output
interface pc_fetch_if;
  logic [31:0] i_b_pc;
  logic        i_b_taken;
  logic        i_stall;
  logic [31:0] o_imem_addr;
  logic        o_imem_req;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_misalign;

  modport master (
    input  i_b_pc, i_b_taken, i_stall, i_imem_ack, i_imem_data,
    output o_imem_addr, o_imem_req, o_valid, o_instr, o_pc, o_misalign
  );

  modport slave (
    output i_b_pc, i_b_taken, i_stall, i_imem_ack, i_imem_data,
    input  o_imem_addr, o_imem_req, o_valid, o_instr, o_pc, o_misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC fetch unit with 2-entry in-order instruction buffer
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned INC      = 4
) (
  input logic         clk,
  input logic         rst,
  pc_fetch_if.master  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [31:0] INC_W  = 32'(INC);

  logic [1:0]  r_state;
  logic [31:0] r_fpc;
  logic [1:0]  r_cnt;
  logic [31:0] r_pc0, r_ins0, r_pc1, r_ins1;
  logic        r_misalign;

  logic w_fetching, w_redir, w_req, w_push, w_pop, w_valid;

  assign w_fetching = (r_state == S_FETCH);
  assign w_redir    = w_fetching && bus.i_b_taken;
  assign w_req      = w_fetching && (r_cnt != 2'd2) && !bus.i_b_taken;
  assign w_push     = w_req && bus.i_imem_ack;
  assign w_valid    = (r_cnt != 2'd0);
  assign w_pop      = w_valid && !bus.i_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fpc      <= RESET_PC;
      r_cnt      <= 2'd0;
      r_pc0      <= 32'd0;
      r_ins0     <= 32'd0;
      r_pc1      <= 32'd0;
      r_ins1     <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_redir) begin
            r_cnt <= 2'd0;
            if (bus.i_b_pc[1:0] != 2'b00) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_fpc <= bus.i_b_pc;
            end
          end else begin
            if (w_push) r_fpc <= r_fpc + INC_W;
            case ({w_push, w_pop})
              2'b01: begin
                r_pc0  <= r_pc1;
                r_ins0 <= r_ins1;
                r_cnt  <= r_cnt - 2'd1;
              end
              2'b10: begin
                if (r_cnt == 2'd0) begin
                  r_pc0  <= r_fpc;
                  r_ins0 <= bus.i_imem_data;
                end else begin
                  r_pc1  <= r_fpc;
                  r_ins1 <= bus.i_imem_data;
                end
                r_cnt <= r_cnt + 2'd1;
              end
              // push needs count<2 and pop needs count>0, so count is 1 here
              2'b11: begin
                r_pc0  <= r_fpc;
                r_ins0 <= bus.i_imem_data;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_imem_addr = r_fpc;
  assign bus.o_imem_req  = w_req;
  assign bus.o_valid     = w_valid;
  assign bus.o_pc        = w_valid ? r_pc0 : 32'd0;
  assign bus.o_instr     = w_valid ? r_ins0 : 32'd0;
  assign bus.o_misalign  = r_misalign;
endmodule
